fp32_mul_responder: RTL and testbench
=====================================

Name: fp32_mul_responder

Overview:
- Responder (slave) side of the team's stb/ack operand/result handshake.
- The dot-product and collision datapaths act as initiators: they present operands on input_a/input_b with strobes and consume output_z.
- This block accepts A, then B, computes the IEEE-754 single-precision product, and presents Z until the initiator acknowledges it.
- It is the multiplier engine instantiated three times per Dot3 stage.

Parameters:
- ROUND_NEAREST, 1, 1 = round-to-nearest-even; 0 = truncate toward zero.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- input_a  in  32  operand A (fp32)
- input_a_stb  in  1  initiator: A valid
- input_a_ack  out  1  responder: ready for A; transfer on clk edge with stb&&ack
- input_b  in  32  operand B (fp32)
- input_b_stb  in  1  initiator: B valid
- input_b_ack  out  1  responder: ready for B
- output_z  out  32  product (fp32); held stable while output_z_stb=1
- output_z_stb  out  1  responder: Z valid
- output_z_ack  in  1  initiator: Z accepted; transfer on stb&&ack

Behaviour:
- Reset (rst=0 at clk edge): state=GET_A, input_a_ack=1, input_b_ack=0, output_z_stb=0, output_z=0. Reset mid-operation abandons the operation; no partial Z is emitted.
- FSM states and sequence: GET_A -> GET_B -> UNPACK -> SPECIAL -> MULTIPLY -> NORMALISE -> ROUND -> PACK -> PUT_Z -> GET_A.
- GET_A: input_a_ack=1. On input_a_stb=1, register A, drop ack, go to GET_B.
- GET_B: input_b_ack=1. On input_b_stb=1, register B, drop ack, go to UNPACK.
- Only one ack is high at any time. Both acks are 0 from B transfer until Z transfer.
- UNPACK: split sign, exponent and mantissa. Exponent is unbiased (minus 127) into 10-bit signed. Implicit 1 is prepended for exp!=0. Denormal inputs are flushed to signed zero (FTZ).
- SPECIAL: sign = sa^sb. Special results skip straight to PUT_Z:
  - NaN in → 0x7FC00000
  - inf×0 → 0x7FC00000
  - inf×finite → signed inf
  - zero×finite → signed zero
  - Otherwise go to MULTIPLY.
- MULTIPLY: 24x24 → 48-bit product, registered; exponent = ea+eb.
- NORMALISE: if product[47]=1, shift right 1 and exponent+1. Keep 24 bits plus guard, round and sticky (OR of the remaining bits).
- ROUND:
  - RNE: increment if guard && (round||sticky||lsb).
  - A mantissa carry-out renormalises (exponent+1).
  - ROUND_NEAREST=0: no increment.
- PACK:
  - exponent > 127 → signed inf (0x7F800000 | sign).
  - exponent < -126 → signed zero (FTZ, no denormal output).
  - Otherwise biased pack.
- PUT_Z: output_z_stb=1, output_z stable. Stay until output_z_ack=1; then stb=0 and go to GET_A, with input_a_ack=1 the next cycle.
- Latency from the B-transfer edge:
  - normal path: output_z_stb high 6 cycles later;
  - special path: 2 cycles later.
- Throughput: one result per operation; there is no overlap.
- Input strobes asserted outside their GET state are ignored. Initiators that tie stb=1 are legal and behave as in the Dot3 datapath.
- An output_z_ack held high before stb rises transfers on the first stb cycle.

Optional Feature:
- Macro FP_MUL_STATUS_EN.
- Defined:
  - Adds output port status (5 bits: invalid, overflow, underflow, inexact, special), registered in PACK/SPECIAL and valid with output_z_stb.
  - Reset value 0.
  - Cleared on GET_A entry.
- Undefined: port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fp32_pkg:
  - FP32_BIAS=127, FP32_EMIN=-126, FP32_EMAX=127
  - FP32_QNAN=32'h7FC00000, FP32_INF=32'h7F800000
  - field-width constants
  - state enum typedef fp_mul_state_t
- Sub-module fp32_round_pack (combinational): takes sign, exponent, 24-bit mantissa, guard/round/sticky and ROUND_NEAREST; returns the 32-bit packed value and flags. It is reusable by the team's adder.

Test Plan:
- A=0x40000000 (2.0), B=0x40400000 (3.0), ack tied 1 → Z=0x40C00000, stb high exactly 6 cycles after B transfer.
- A=0x3F800001, B=0x3F800001: ROUND_NEAREST=1 → Z=0x3F800002; ROUND_NEAREST=0 → Z=0x3F800002 via truncation (check inexact=1 when FP_MUL_STATUS_EN).
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, stb 2 cycles after B.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x7FC00000 × 1.0 → 0x7FC00000.
- Overflow/underflow: 0x7F7FFFFF × 0x40000000 → 0x7F800000; 0x00800000 × 0x3F000000 → 0x00000000 (FTZ).
- Backpressure: hold output_z_ack=0 for 10 cycles → Z and stb stable, both input acks 0. Ack once → next cycle stb=0, input_a_ack=1.
- Reset mid-op: drive rst=0 in the MULTIPLY cycle → next cycle all outputs at reset values. A fresh 1.5×1.5 (0x3FC00000 each) then → 0x40100000.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared single-precision constants, field widths, status flag
// positions and the multiplier FSM state type.
package fp32_pkg;

  localparam int FP32_WIDTH  = 32;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP32_MANT_W = 24;
  localparam int FP32_PROD_W = 48;
  localparam int FP32_EXPU_W = 10;
  localparam int FP32_FLAG_W = 5;

  localparam logic signed [FP32_EXPU_W-1:0] FP32_BIAS = 10'sd127;
  localparam logic signed [FP32_EXPU_W-1:0] FP32_EMIN = -10'sd126;
  localparam logic signed [FP32_EXPU_W-1:0] FP32_EMAX = 10'sd127;

  localparam logic [FP32_WIDTH-1:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [FP32_WIDTH-1:0] FP32_INF  = 32'h7F800000;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_SPECIAL   = 0;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL,
    MULTIPLY,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } fp_mul_state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: combinational round (RNE or truncate) and pack of a
// normalised sign/exponent/24-bit mantissa with guard, round and sticky bits.
// Out-of-range exponents saturate to signed infinity or flush to signed zero.
// A mantissa without its leading one is treated as an exact zero result.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic                          i_sign,
  input  logic signed [FP32_EXPU_W-1:0] i_exp,
  input  logic [FP32_MANT_W-1:0]        i_mant,
  input  logic                          i_guard,
  input  logic                          i_round,
  input  logic                          i_sticky,
  input  logic                          i_roundNearest,
  output logic [FP32_WIDTH-1:0]         o_packed,
  output logic [FP32_FLAG_W-1:0]        o_flags
);

  logic                          w_inc;
  logic [FP32_MANT_W:0]          w_sum;
  logic [FP32_MANT_W-1:0]        w_mant;
  logic signed [FP32_EXPU_W-1:0] w_exp;
  logic                          w_inexact;

  // Round the mantissa, renormalise on carry-out, then range-check and pack.
  always_comb begin
    w_inc     = i_roundNearest & i_guard & (i_round | i_sticky | i_mant[0]);
    w_sum     = {1'b0, i_mant} + {{FP32_MANT_W{1'b0}}, w_inc};
    w_mant    = w_sum[FP32_MANT_W-1:0];
    w_exp     = i_exp;
    if (w_sum[FP32_MANT_W]) begin
      w_mant = w_sum[FP32_MANT_W:1];
      w_exp  = i_exp + 10'sd1;
    end
    w_inexact = i_guard | i_round | i_sticky;
    o_flags   = '0;
    o_packed  = '0;
    if (!w_mant[FP32_MANT_W-1]) begin
      o_packed = {i_sign, {(FP32_WIDTH-1){1'b0}}};
    end else if (w_exp > FP32_EMAX) begin
      o_packed                = {i_sign, FP32_INF[FP32_WIDTH-2:0]};
      o_flags[FLAG_OVERFLOW]  = 1'b1;
      o_flags[FLAG_INEXACT]   = 1'b1;
    end else if (w_exp < FP32_EMIN) begin
      o_packed                = {i_sign, {(FP32_WIDTH-1){1'b0}}};
      o_flags[FLAG_UNDERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      o_packed              = {i_sign, FP32_EXP_W'(w_exp + FP32_BIAS), w_mant[FP32_FRAC_W-1:0]};
      o_flags[FLAG_INEXACT] = w_inexact;
    end
  end

endmodule

// File: rtl/fp32_mul_responder.sv
// fp32_mul_responder: stb/ack responder that accepts operand A, then B,
// multiplies them as IEEE-754 single precision (denormals flushed to zero)
// and holds Z until the initiator acknowledges it.
// Optional status port (invalid, overflow, underflow, inexact, special)
// is enabled by defining FP_MUL_STATUS_EN.
module fp32_mul_responder
  import fp32_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FP32_WIDTH-1:0]  input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  input  logic [FP32_WIDTH-1:0]  input_b,
  input  logic                   input_b_stb,
  output logic                   input_b_ack,
  output logic [FP32_WIDTH-1:0]  output_z,
  output logic                   output_z_stb,
`ifdef FP_MUL_STATUS_EN
  output logic [FP32_FLAG_W-1:0] status,
`endif
  input  logic                   output_z_ack
);

  fp_mul_state_t r_state, w_nextState;

  logic [FP32_WIDTH-1:0]         r_a, r_b, r_z, r_packed;
  logic                          r_aSign, r_bSign;
  logic signed [FP32_EXPU_W-1:0] r_aExp, r_bExp, r_zExp;
  logic [FP32_MANT_W-1:0]        r_aMant, r_bMant, r_zMant;
  logic                          r_aNan, r_bNan, r_aInf, r_bInf, r_aZero, r_bZero;
  logic [FP32_PROD_W-1:0]        r_product;
  logic                          r_guard, r_round, r_sticky;

  logic                          w_zSign;
  logic                          w_isSpecial;
  logic [FP32_WIDTH-1:0]         w_specialZ;
  logic [FP32_FLAG_W-1:0]        w_specialFlags;
  logic [FP32_WIDTH-1:0]         w_packed;
  logic [FP32_FLAG_W-1:0]        w_flags;

  assign output_z = r_z;
  assign w_zSign  = r_aSign ^ r_bSign;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= GET_A;
    else      r_state <= w_nextState;
  end

  // Next-state sequencing and Moore handshake outputs.
  always_comb begin
    w_nextState  = r_state;
    input_a_ack  = 1'b0;
    input_b_ack  = 1'b0;
    output_z_stb = 1'b0;
    case (r_state)
      GET_A: begin
        input_a_ack = 1'b1;
        if (input_a_stb) w_nextState = GET_B;
      end
      GET_B: begin
        input_b_ack = 1'b1;
        if (input_b_stb) w_nextState = UNPACK;
      end
      UNPACK:    w_nextState = SPECIAL;
      SPECIAL:   w_nextState = w_isSpecial ? PUT_Z : MULTIPLY;
      MULTIPLY:  w_nextState = NORMALISE;
      NORMALISE: w_nextState = ROUND;
      ROUND:     w_nextState = PACK;
      PACK:      w_nextState = PUT_Z;
      PUT_Z: begin
        output_z_stb = 1'b1;
        if (output_z_ack) w_nextState = GET_A;
      end
      default:   w_nextState = GET_A;
    endcase
  end

  // Classify the unpacked operands and pick the short-circuit result.
  always_comb begin
    w_isSpecial                  = r_aNan | r_bNan | r_aInf | r_bInf | r_aZero | r_bZero;
    w_specialZ                   = {w_zSign, {(FP32_WIDTH-1){1'b0}}};
    w_specialFlags               = '0;
    w_specialFlags[FLAG_SPECIAL] = 1'b1;
    if (r_aNan || r_bNan || (r_aInf && r_bZero) || (r_bInf && r_aZero)) begin
      w_specialZ                   = FP32_QNAN;
      w_specialFlags[FLAG_INVALID] = 1'b1;
    end else if (r_aInf || r_bInf) begin
      w_specialZ = {w_zSign, FP32_INF[FP32_WIDTH-2:0]};
    end
  end

  fp32_round_pack u_roundPack (
    .i_sign         (w_zSign),
    .i_exp          (r_zExp),
    .i_mant         (r_zMant),
    .i_guard        (r_guard),
    .i_round        (r_round),
    .i_sticky       (r_sticky),
    .i_roundNearest (ROUND_NEAREST),
    .o_packed       (w_packed),
    .o_flags        (w_flags)
  );

  // Datapath: each FSM state owns one step of the multiply pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_z <= '0;
    end else begin
      case (r_state)
        GET_A: if (input_a_stb) r_a <= input_a;
        GET_B: if (input_b_stb) r_b <= input_b;
        UNPACK: begin
          r_aSign <= r_a[31];
          r_bSign <= r_b[31];
          r_aExp  <= $signed({2'b00, r_a[30:23]}) - FP32_BIAS;
          r_bExp  <= $signed({2'b00, r_b[30:23]}) - FP32_BIAS;
          r_aMant <= (r_a[30:23] == 8'h00) ? '0 : {1'b1, r_a[22:0]};
          r_bMant <= (r_b[30:23] == 8'h00) ? '0 : {1'b1, r_b[22:0]};
          r_aZero <= (r_a[30:23] == 8'h00);
          r_bZero <= (r_b[30:23] == 8'h00);
          r_aInf  <= (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
          r_bInf  <= (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
          r_aNan  <= (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
          r_bNan  <= (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
        end
        SPECIAL: if (w_isSpecial) r_z <= w_specialZ;
        MULTIPLY: begin
          r_product <= FP32_PROD_W'(r_aMant) * FP32_PROD_W'(r_bMant);
          r_zExp    <= r_aExp + r_bExp;
        end
        NORMALISE: begin
          if (r_product[47]) begin
            r_zMant  <= r_product[47:24];
            r_guard  <= r_product[23];
            r_round  <= r_product[22];
            r_sticky <= |r_product[21:0];
            r_zExp   <= r_zExp + 10'sd1;
          end else begin
            r_zMant  <= r_product[46:23];
            r_guard  <= r_product[22];
            r_round  <= r_product[21];
            r_sticky <= |r_product[20:0];
          end
        end
        ROUND: r_packed <= w_packed;
        PACK:  r_z <= r_packed;
        default: ;
      endcase
    end
  end

`ifdef FP_MUL_STATUS_EN
  logic [FP32_FLAG_W-1:0] r_packFlags;

  // Status follows Z: captured with the result, wiped when GET_A is re-entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      status <= '0;
    end else begin
      if (r_state == ROUND) r_packFlags <= w_flags;
      if (r_state == SPECIAL && w_isSpecial) status <= w_specialFlags;
      if (r_state == PACK) status <= r_packFlags;
      if (r_state == PUT_Z && output_z_ack) status <= '0;
    end
  end
`else
  logic w_unusedFlags;
  assign w_unusedFlags = ^{w_flags, w_specialFlags};
`endif

endmodule

// File: tb/tb_fp32_mul_responder.sv
// tb_fp32_mul_responder: randomized and directed bench for the fp32
// multiplier responder, checked against a real-arithmetic reference model.
module tb_fp32_mul_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        output_z_stb, output_z_ack;
`ifdef FP_MUL_STATUS_EN
  logic [4:0]  status;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_mul_responder #(.ROUND_NEAREST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
`ifdef FP_MUL_STATUS_EN
    .status       (status),
`endif
    .output_z_ack (output_z_ack)
  );

  // Exact conversion of a normal fp32 value to a double.
  function automatic real fp32ToReal(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round a double to fp32 (nearest-even), saturate overflow, flush underflow.
  function automatic logic [31:0] realToFp32(input real r);
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    logic [28:0] rem;
    d   = $realtobits(r);
    e   = int'(d[62:52]) - 1023;
    m   = {1'b0, 1'b1, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e > 127) return {d[63], 8'hFF, 23'd0};
    if (e < -126) return {d[63], 31'd0};
    return {d[63], 8'(e + 127), m[22:0]};
  endfunction

  function automatic bit isSpecialIn(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // Reference product: special-value rules first, then exact real multiply.
  function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b);
    bit aZero, bZero, aInf, bInf, aNan, bNan, s;
    aZero = (a[30:23] == 8'h00);
    bZero = (b[30:23] == 8'h00);
    aInf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bInf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    aNan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bNan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    s     = a[31] ^ b[31];
    if (aNan || bNan) return 32'h7FC00000;
    if ((aInf && bZero) || (bInf && aZero)) return 32'h7FC00000;
    if (aInf || bInf) return {s, 31'h7F800000};
    if (aZero || bZero) return {s, 31'd0};
    return realToFp32(fp32ToReal(a) * fp32ToReal(b));
  endfunction

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    int          sel;
    v   = $urandom();
    sel = $urandom_range(0, 9);
    if (sel == 0) begin
      case ($urandom_range(0, 5))
        0:       v = 32'h00000000;
        1:       v = 32'h80000000;
        2:       v = 32'h7F800000;
        3:       v = 32'hFF800000;
        4:       v = 32'h7FC00000;
        default: v = {v[31], 8'h00, v[22:0]};
      endcase
    end else if (sel == 1) begin
      if ($urandom_range(0, 1) == 1) v[30:23] = 8'($urandom_range(1, 12));
      else                           v[30:23] = 8'($urandom_range(243, 254));
    end else begin
      v[30:23] = 8'($urandom_range(64, 190));
    end
    return v;
  endfunction

  // Transfer A then B through their handshakes; ok drops if an ack never comes.
  task automatic sendAB(input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    input_a = a;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) ok = 1'b0;
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    @(negedge clk);
    input_b = b;
    input_b_stb = 1'b1;
    n = 0;
    while (!input_b_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!input_b_ack) ok = 1'b0;
    @(posedge clk);
    #1 input_b_stb = 1'b0;
  endtask

  // Count edges after the B transfer until Z is strobed (-1 if it never is).
  task automatic waitResult(output logic [31:0] z, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) begin
        lat = i;
        break;
      end
    end
    z = output_z;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] z, output int lat);
    bit ok;
    sendAB(a, b, ok);
    waitResult(z, lat);
    if (!ok) lat = -1;
  endtask

  task automatic ackResult();
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_a_ack: got %b expected 1", input_a_ack);
    end
    checks++;
    if (input_b_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b_ack: got %b expected 0", input_b_ack);
    end
    checks++;
    if (output_z_stb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_z_stb: got %b expected 0", output_z_stb);
    end
    checks++;
    if (output_z !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_z: got %h expected 00000000", output_z);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] z;
    int          lat;
    output_z_ack = 1'b1;
    applyStimulus(32'h40000000, 32'h40400000, z, lat);
    checks++;
    if (z !== 32'h40C00000) begin
      errors++;
      $display("[TB] FAIL basic_z: got %h expected 40c00000", z);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected 6", lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_release: got stb=%b a_ack=%b expected stb=0 a_ack=1",
               output_z_stb, input_a_ack);
    end
    output_z_ack = 1'b0;
  endtask

  task automatic test_rounding();
    logic [31:0] as [4] = '{32'h3F800001, 32'h3FFFFFFF, 32'h3FBFFFFF, 32'h3F8000FF};
    logic [31:0] bs [4] = '{32'h3F800001, 32'h3FFFFFFF, 32'h3FAAAAAB, 32'h3F7FFF01};
    logic [31:0] z, expZ;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      expZ = modelMul(as[i], bs[i]);
      applyStimulus(as[i], bs[i], z, lat);
      checks++;
      if (z !== expZ) begin
        errors++;
        $display("[TB] FAIL round_z[%0d]: got %h expected %h", i, z, expZ);
      end
`ifdef FP_MUL_STATUS_EN
      if (i == 0) begin
        checks++;
        if (status !== 5'b00010) begin
          errors++;
          $display("[TB] FAIL round_status: got %b expected 00010", status);
        end
      end
`endif
      ackResult();
    end
  endtask

  task automatic test_specials();
    logic [31:0] as [5] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F7FFFFF, 32'h00800000};
    logic [31:0] bs [5] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000};
    logic [31:0] zs [5] = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    int          ls [5] = '{2, 2, 2, 6, 6};
    logic [31:0] z;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(as[i], bs[i], z, lat);
      checks++;
      if (z !== zs[i]) begin
        errors++;
        $display("[TB] FAIL special_z[%0d]: got %h expected %h", i, z, zs[i]);
      end
      checks++;
      if (lat !== ls[i]) begin
        errors++;
        $display("[TB] FAIL special_latency[%0d]: got %0d expected %0d", i, lat, ls[i]);
      end
`ifdef FP_MUL_STATUS_EN
      if (i == 0) begin
        checks++;
        if (status !== 5'b10001) begin
          errors++;
          $display("[TB] FAIL special_status: got %b expected 10001", status);
        end
      end
`endif
      ackResult();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, z, expZ;
    int          lat, expLat;
    for (int i = 0; i < 40; i++) begin
      a      = randOperand();
      b      = randOperand();
      expZ   = modelMul(a, b);
      expLat = isSpecialIn(a, b) ? 2 : 6;
      applyStimulus(a, b, z, lat);
      checks++;
      if (z !== expZ) begin
        errors++;
        $display("[TB] FAIL random_z[%0d]: %h * %h got %h expected %h", i, a, b, z, expZ);
      end
      checks++;
      if (lat !== expLat) begin
        errors++;
        $display("[TB] FAIL random_latency[%0d]: got %0d expected %0d", i, lat, expLat);
      end
      ackResult();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] z, expZ;
    int          lat;
    expZ = modelMul(32'h40490FDB, 32'h402DF854);
    applyStimulus(32'h40490FDB, 32'h402DF854, z, lat);
    checks++;
    if (z !== expZ) begin
      errors++;
      $display("[TB] FAIL bp_z: got %h expected %h", z, expZ);
    end
    input_a = 32'h3F800000;
    input_b = 32'h3F800000;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (output_z !== expZ || output_z_stb !== 1'b1 || input_a_ack !== 1'b0 || input_b_ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got z=%h stb=%b a_ack=%b b_ack=%b expected z=%h stb=1 acks=0",
                 i, output_z, output_z_stb, input_a_ack, input_b_ack, expZ);
      end
    end
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    ackResult();
    checks++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got stb=%b a_ack=%b expected stb=0 a_ack=1",
               output_z_stb, input_a_ack);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] z;
    int          lat;
    bit          ok;
    sendAB(32'h40000000, 32'h40400000, ok);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (input_a_ack !== 1'b1 || input_b_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got a_ack=%b b_ack=%b stb=%b z=%h expected 1 0 0 00000000",
               input_a_ack, input_b_ack, output_z_stb, output_z);
    end
    rst = 1'b1;
    applyStimulus(32'h3FC00000, 32'h3FC00000, z, lat);
    checks++;
    if (z !== 32'h40100000) begin
      errors++;
      $display("[TB] FAIL midop_fresh_z: got %h expected 40100000", z);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("[TB] FAIL midop_fresh_latency: got %0d expected 6", lat);
    end
    ackResult();
  endtask

  task automatic test_back_to_back();
    logic [31:0] expZ;
    int          lastC, got;
    expZ = modelMul(32'h3FC00000, 32'h40000000);
    lastC = -1;
    got = 0;
    input_a = 32'h3FC00000;
    input_b = 32'h40000000;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    output_z_ack = 1'b1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) begin
        checks++;
        if (output_z !== expZ) begin
          errors++;
          $display("[TB] FAIL b2b_z[%0d]: got %h expected %h", got, output_z, expZ);
        end
        if (got > 0) begin
          checks++;
          if (c - lastC !== 9) begin
            errors++;
            $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected 9", got, c - lastC);
          end
        end
        lastC = c;
        got++;
      end
    end
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d expected 3", got);
    end
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  // Hard stop in case a handshake wedges somewhere unbounded.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run every scenario in sequence and report.
  initial begin
    rst          = 1'b0;
    input_a      = '0;
    input_b      = '0;
    input_a_stb  = 1'b0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
